// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_arb_pkg
// Brief   : Owner encoding, timeout counter width and arbitration helper
//           shared by the dual-master Wishbone arbiter.
// Revision: 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int TO_CNT_W = 16;

    // last_m1 = 1 means m1 held the bus most recently, so m0 wins a tie.
    function automatic logic [1:0] pick_owner(input logic req0,
                                              input logic req1,
                                              input logic last_m1);
        logic [1:0] owner;
        owner = OWN_NONE;
        if (req0 && req1) begin
            owner = last_m1 ? OWN_M0 : OWN_M1;
        end else if (req0) begin
            owner = OWN_M0;
        end else if (req1) begin
            owner = OWN_M1;
        end
        return owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arb_timeout.sv
`default_nettype none
// ============================================================================
// Module  : wb_arb_timeout
// Brief   : Counts consecutive unanswered strobe cycles and fires a one-cycle
//           timeout when the count reaches TIMEOUT_CYCLES-1.
// Revision: 1.0  initial release
// ============================================================================
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    input  logic ack_i,
    input  logic err_i,
    output logic fire_o
);

    localparam logic [TO_CNT_W-1:0] c_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;
    logic                w_wait;

    // A real slave response in the same cycle always beats the timeout.
    assign w_wait = stb_i & ~ack_i & ~err_i;
    assign fire_o = w_wait & (cnt_q == c_LIMIT);

    always_comb begin
        cnt_d = '0;
        if (w_wait && !fire_o) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_dual_master_arbiter
// Brief   : Round-robin arbiter sharing one Wishbone classic slave between two
//           masters; ownership lasts a whole cyc tenure. Define
//           WB_ARB_TIMEOUT_EN to add bus-timeout error generation.
// Revision: 1.0  initial release
// ============================================================================
module wb_dual_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..65535");
    end

    logic [1:0] owner_q;
    logic [1:0] owner_d;
    logic       last_q;     // 1: m1 owned the bus most recently
    logic       last_d;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_cyc_raw;
    logic       w_stb_raw;
    logic       w_to_fire;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: an owner keeps the bus until its cyc drops, and every
    // release passes through IDLE so the other master gets the next turn.
    // ------------------------------------------------------------------
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        case (owner_q)
            OWN_M0: begin
                if (!m0_cyc_i) begin
                    owner_d = OWN_NONE;
                    last_d  = 1'b0;
                end
            end
            OWN_M1: begin
                if (!m1_cyc_i) begin
                    owner_d = OWN_NONE;
                    last_d  = 1'b1;
                end
            end
            default: begin
                owner_d = pick_owner(m0_cyc_i, m1_cyc_i, last_q);
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_gnt0    = (owner_q == OWN_M0);
    assign w_gnt1    = (owner_q == OWN_M1);
    assign w_cyc_raw = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
    assign w_stb_raw = (w_gnt0 & m0_cyc_i & m0_stb_i) | (w_gnt1 & m1_cyc_i & m1_stb_i);

    always_comb begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        if (w_gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
        end
        s_cyc_o   = w_cyc_raw;
        s_stb_o   = w_stb_raw & ~w_to_fire;

        // Responses reach only a master that currently holds an active cycle.
        m0_ack_o  = w_gnt0 & m0_cyc_i & s_ack_i;
        m1_ack_o  = w_gnt1 & m1_cyc_i & s_ack_i;
        m0_err_o  = w_gnt0 & m0_cyc_i & (s_err_i | w_to_fire);
        m1_err_o  = w_gnt1 & m1_cyc_i & (s_err_i | w_to_fire);
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;

        grant_o   = owner_q;
        timeout_o = w_to_fire;
    end

`ifdef WB_ARB_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (wb_clk),
        .rst_ni (wb_rst_n),
        .stb_i  (w_stb_raw),
        .ack_i  (s_ack_i),
        .err_i  (s_err_i),
        .fire_o (w_to_fire)
    );
`else
    assign w_to_fire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_dual_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_dual_master_arbiter
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a behavioural ownership model.
// Revision: 1.0  initial release
// ============================================================================
module tb_wb_dual_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            wb_clk = 1'b0;
    logic            wb_rst_n;
    logic [AW-1:0]   m0_adr_i, m1_adr_i;
    logic [DW-1:0]   m0_dat_i, m1_dat_i;
    logic [DW/8-1:0] m0_sel_i, m1_sel_i;
    logic            m0_we_i, m0_cyc_i, m0_stb_i;
    logic            m1_we_i, m1_cyc_i, m1_stb_i;
    logic [DW-1:0]   m0_dat_o, m1_dat_o;
    logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic [1:0]      grant_o;
    logic            timeout_o;

    wb_dual_master_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk    (wb_clk),    .wb_rst_n  (wb_rst_n),
        .m0_adr_i  (m0_adr_i),  .m0_dat_i  (m0_dat_i),  .m0_sel_i (m0_sel_i),
        .m0_we_i   (m0_we_i),   .m0_cyc_i  (m0_cyc_i),  .m0_stb_i (m0_stb_i),
        .m0_dat_o  (m0_dat_o),  .m0_ack_o  (m0_ack_o),  .m0_err_o (m0_err_o),
        .m1_adr_i  (m1_adr_i),  .m1_dat_i  (m1_dat_i),  .m1_sel_i (m1_sel_i),
        .m1_we_i   (m1_we_i),   .m1_cyc_i  (m1_cyc_i),  .m1_stb_i (m1_stb_i),
        .m1_dat_o  (m1_dat_o),  .m1_ack_o  (m1_ack_o),  .m1_err_o (m1_err_o),
        .s_adr_o   (s_adr_o),   .s_dat_o   (s_dat_o),   .s_sel_o  (s_sel_o),
        .s_we_o    (s_we_o),    .s_cyc_o   (s_cyc_o),   .s_stb_o  (s_stb_o),
        .s_dat_i   (s_dat_i),   .s_ack_i   (s_ack_i),   .s_err_i  (s_err_i),
        .grant_o   (grant_o),   .timeout_o (timeout_o)
    );

    always #5 wb_clk = ~wb_clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: owner -1 = nobody, 0/1 = master; last = most recent owner.
    int m_owner;
    int m_last;
    int m_wait;

    typedef struct packed {
        logic       m0c, m0s, m1c, m1s, ack, err;
        logic [1:0] grant;
        logic       scyc, sstb, a0, a1, e0, e1;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge wb_clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        wb_rst_n = 1'b0;
        next_cycle();
        next_cycle();
        wb_rst_n = 1'b1;
        m_owner = -1;
        m_last  = 1;
        m_wait  = 0;
    endtask

    // Compare every output against the ownership rules, then advance the model.
    task automatic model_step(input string nm);
        logic [1:0]      cyc, stb;
        logic            own_cyc, own_stb, fire;
        logic [1:0]      e_grant;
        logic [AW-1:0]   e_adr;
        logic [DW-1:0]   e_dat;
        logic [DW/8-1:0] e_sel;
        logic            e_we;
        logic [191:0]    act, exp;
        cyc     = {m1_cyc_i, m0_cyc_i};
        stb     = {m1_stb_i, m0_stb_i};
        own_cyc = (m_owner >= 0) && cyc[m_owner];
        own_stb = own_cyc && stb[m_owner];
        fire    = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        fire    = own_stb && !s_ack_i && !s_err_i && (m_wait == TO - 1);
`endif
        e_grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
        e_adr   = (m_owner == 1) ? m1_adr_i : m0_adr_i;
        e_dat   = (m_owner == 1) ? m1_dat_i : m0_dat_i;
        e_sel   = (m_owner == 1) ? m1_sel_i : m0_sel_i;
        e_we    = (m_owner == 1) ? m1_we_i  : m0_we_i;
        exp = {50'd0, e_grant, own_cyc, own_stb && !fire, e_we, e_adr, e_dat, e_sel,
               own_cyc && m_owner == 0 && s_ack_i, own_cyc && m_owner == 0 && (s_err_i || fire),
               own_cyc && m_owner == 1 && s_ack_i, own_cyc && m_owner == 1 && (s_err_i || fire),
               s_dat_i, s_dat_i, fire};
        act = {50'd0, grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
               m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o, timeout_o};
        chk(nm, act, exp);
        m_wait = (own_stb && !s_ack_i && !s_err_i && !fire) ? m_wait + 1 : 0;
        if (m_owner < 0) begin
            if (cyc == 2'b11)  m_owner = 1 - m_last;
            else if (cyc[0])   m_owner = 0;
            else if (cyc[1])   m_owner = 1;
        end else if (!cyc[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  k;
        logic f;

        // fields: m0c m0s m1c m1s ack err _ grant _ scyc sstb a0 a1 e0 e1
        vt[0]  = 14'b111110_00_000000;
        vt[1]  = 14'b111100_01_110000;
        vt[2]  = 14'b111110_01_111000;
        vt[3]  = 14'b001110_01_000000;
        vt[4]  = 14'b111100_00_000000;
        vt[5]  = 14'b111101_10_110001;
        vt[6]  = 14'b110000_10_000000;
        vt[7]  = 14'b111100_00_000000;
        vt[8]  = 14'b101100_01_100000;
        vt[9]  = 14'b000000_01_000000;
        vt[10] = 14'b001000_00_000000;
        vt[11] = 14'b001100_10_110000;

        // Reset state, with a stray slave ack that must be ignored.
        idle_inputs();
        wb_rst_n = 1'b0;
        s_ack_i  = 1'b1;
        s_err_i  = 1'b1;
        #3;
        chk("reset_outputs",
            {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o},
            9'd0);

        // Arbitration / routing table.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            m0_cyc_i = vt[i].m0c; m0_stb_i = vt[i].m0s;
            m1_cyc_i = vt[i].m1c; m1_stb_i = vt[i].m1s;
            s_ack_i  = vt[i].ack; s_err_i  = vt[i].err;
            #3;
            chk($sformatf("table_%0d", i),
                {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o},
                {vt[i].grant, vt[i].scyc, vt[i].sstb, vt[i].a0, vt[i].a1, vt[i].e0, vt[i].e1});
            next_cycle();
        end

        // m0 single read, slave answers two cycles after seeing stb.
        do_reset();
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
        k = 0;
        #3;
        while (!s_stb_o && k < 8) begin
            next_cycle();
            #3;
            k++;
        end
        chk("t1_grant_latency", 192'(k), 192'd1);
        chk("t1_adr", s_adr_o, 32'h100);
        next_cycle();
        #3;
        chk("t1_no_early_ack", m0_ack_o, 1'b0);
        next_cycle();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #3;
        chk("t1_read", {grant_o, m0_ack_o, m1_ack_o, m0_dat_o}, {2'b01, 1'b1, 1'b0, 32'hDEADBEEF});
        next_cycle();
        idle_inputs();

        // m1 burst of four writes while m0 waits.
        do_reset();
        next_cycle();
        m1_cyc_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'hF;
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h300;
        for (int b = 0; b < 4; b++) begin
            m1_stb_i = 1'b1; m1_adr_i = 32'h200 + 32'(4 * b); m1_dat_i = 32'hA0 + 32'(b);
            s_ack_i  = 1'b1;
            #3;
            chk($sformatf("t3_beat_%0d", b),
                {grant_o, s_we_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o},
                {2'b10, 1'b1, 32'h200 + 32'(4 * b), 32'hA0 + 32'(b), 1'b1, 1'b0});
            next_cycle();
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        #3;
        chk("t3_release", {grant_o, s_cyc_o}, {2'b10, 1'b0});
        next_cycle();
        #3;
        chk("t3_idle_gap", grant_o, 2'b00);
        next_cycle();
        #3;
        chk("t3_m0_granted", {grant_o, s_adr_o}, {2'b01, 32'h300});
        next_cycle();
        idle_inputs();

        // Slave never answers: timeout behaviour depends on the build.
        do_reset();
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        next_cycle();
        for (int i = 1; i <= 20; i++) begin
            f = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            f = ((i % TO) == 0);
`endif
            #3;
            chk($sformatf("t4_wait_%0d", i), {m0_err_o, timeout_o, s_stb_o}, {f, f, !f});
            next_cycle();
        end
        idle_inputs();

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        next_cycle();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        next_cycle();
        s_ack_i = 1'b1;
        #3;
        chk("t6_pre_reset_ack", {grant_o, m0_ack_o}, {2'b01, 1'b1});
        #1;
        wb_rst_n = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        #1;
        chk("t6_async_clear", {grant_o, s_cyc_o, s_stb_o, m0_ack_o}, 5'd0);
        next_cycle();
        next_cycle();
        wb_rst_n = 1'b1;
        s_ack_i  = 1'b0;
        next_cycle();
        #3;
        chk("t6_m0_wins_tie", grant_o, 2'b01);
        idle_inputs();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            next_cycle();
            if ($urandom_range(0, 3) == 0) m0_cyc_i = ~m0_cyc_i;
            if ($urandom_range(0, 3) == 0) m1_cyc_i = ~m1_cyc_i;
            m0_stb_i = 1'($urandom_range(0, 1));
            m1_stb_i = 1'($urandom_range(0, 1));
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_we_i  = 1'($urandom); m1_we_i  = 1'($urandom);
            s_dat_i  = $urandom;
            s_ack_i  = ($urandom_range(0, 2) == 0);
            s_err_i  = ($urandom_range(0, 15) == 0);
            #3;
            model_step($sformatf("rand_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
